alu_arbiter: RTL and testbench

- Shares one registered 4-bit ALU (ADD/SUB/AND/OR/XOR/NOT/SHR/SHL, carry flag) between two requesters.
- Accepts operations over a valid/ready handshake and arbitrates round-robin.
- Drives the ALU operand/opcode inputs, waits the ALU latency, and returns result plus carry to the winning requester as a one-cycle response pulse.
- Sits between the control units and the shared ALU instance.

---
 rtl/alu_arb_pkg.sv | 19 +
 rtl/alu_arbiter_if.sv | 29 ++
 rtl/alu_arbiter_rr_arb2.sv | 19 +
 rtl/alu_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared opcode and FSM encodings for the two-requester ALU arbiter.
package alu_arb_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side request/response bundle for alu_arbiter (both requesters).
interface alu_arbiter_if #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
);
    logic              req0_valid, req0_ready;
    logic [DATA_W-1:0] req0_a, req0_b;
    logic [OP_W-1:0]   req0_op;
    logic              req1_valid, req1_ready;
    logic [DATA_W-1:0] req1_a, req1_b;
    logic [OP_W-1:0]   req1_op;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_carry;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_carry
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_carry
    );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input grant logic. ALU_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins);
// default is round-robin where ptr picks the winner of a simultaneous request.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic ptr,
    output logic grant0,
    output logic grant1
);
`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ptr;
    assign grant0 = valid0;
    assign grant1 = valid1 && !valid0;
`else
    assign grant0 = valid0 && (!valid1 || !ptr);
    assign grant1 = valid1 && (!valid0 || ptr);
`endif
endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters; one op in flight at a time.
// Arbitration policy set by ALU_ARB_FIXED_PRIO_EN inside rr_arb2.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int OP_W    = 3,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry
);
    localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gid_q, gid_d;
    logic              ptr_q, ptr_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              grant0, grant1, idle;

    rr_arb2 u_arb (
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .ptr    (ptr_q),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    // Ready is gated by rst_n so no handshake can complete while held in reset.
    assign idle           = rst_n && (state_q == ST_IDLE);
    assign bus.req0_ready = idle && grant0;
    assign bus.req1_ready = idle && grant1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gid_d        = gid_q;
        ptr_d        = ptr_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req0_ready || bus.req1_ready) begin
                    alu_a_d  = bus.req1_ready ? bus.req1_a  : bus.req0_a;
                    alu_b_d  = bus.req1_ready ? bus.req1_b  : bus.req0_b;
                    alu_op_d = bus.req1_ready ? bus.req1_op : bus.req0_op;
                    gid_d    = bus.req1_ready;
                    cnt_d    = CNT_W'(ALU_LAT);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_result_d = alu_result;
                    rsp_carry_d  = alu_carry;
                    rsp0_valid_d = !gid_q;
                    rsp1_valid_d = gid_q;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                ptr_d   = !gid_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            gid_q        <= 1'b0;
            ptr_q        <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gid_q        <= gid_d;
            ptr_q        <= ptr_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_op         = alu_op_q;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter (round-robin build, ALU_LAT=1).
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    typedef struct {
        bit         id;
        logic [3:0] res;
        logic       c;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_carry;
    int         cyc = 0;
    int         vectors = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    bit         ord_q[$];
    int         rsp_cyc[$];

    alu_arbiter_if #(.DATA_W(4), .OP_W(3)) bus ();

    alu_arbiter #(.DATA_W(4), .OP_W(3), .ALU_LAT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_carry  (alu_carry)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU fed by the registered operands; result valid within one cycle.
    always_comb begin
        {alu_carry, alu_result} = 5'd0;
        case (alu_op)
            OP_ADD: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND: alu_result = alu_a & alu_b;
            OP_OR:  alu_result = alu_a | alu_b;
            OP_XOR: alu_result = alu_a ^ alu_b;
            OP_NOT: alu_result = ~alu_a;
            OP_SHR: alu_result = alu_a >> alu_b;
            OP_SHL: alu_result = alu_a << alu_b;
            default: alu_result = 4'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every response pulse.
    always @(negedge clk) begin
        chk("ready_exclusive", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
        if (bus.rsp0_valid || bus.rsp1_valid) begin
            exp_t e;
            chk("rsp_both", {31'd0, bus.rsp0_valid & bus.rsp1_valid}, 32'd0);
            rsp_cyc.push_back(cyc);
            if (ord_q.size() == 0) chk("rsp_unexpected_order", 32'd1, 32'd0);
            else chk("rsp_grant_order", {31'd0, bus.rsp1_valid}, {31'd0, ord_q.pop_front()});
            if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("rsp_id", {31'd0, bus.rsp1_valid}, {31'd0, e.id});
                chk("rsp_result", {28'd0, bus.rsp_result}, {28'd0, e.res});
                chk("rsp_carry", {31'd0, bus.rsp_carry}, {31'd0, e.c});
                chk("rsp_latency", cyc, e.cyc + 2);
            end
        end
    end

    task automatic set_req(input bit id, input logic v, input logic [3:0] a, b, input logic [2:0] op);
        if (id) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    task automatic drive(input bit id, input logic [3:0] a, b, input logic [2:0] op,
                         input logic [3:0] er, input logic ec);
        exp_t e;
        bit   done;
        done = 0;
        set_req(id, 1'b1, a, b, op);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                e.id = id; e.res = er; e.c = ec; e.cyc = cyc;
                exp_q.push_back(e);
                done = 1;
            end
        end
        if (done) begin
            @(posedge clk);
            #1;
        end else chk(id ? "req1_grant_timeout" : "req0_grant_timeout", 32'd1, 32'd0);
        set_req(id, 1'b0, a, b, op);
    endtask

    task automatic drain();
        bit empty;
        empty = 0;
        for (int i = 0; i < 60 && !empty; i++) begin
            @(negedge clk);
            empty = (exp_q.size() == 0) && (ord_q.size() == 0);
        end
        if (!empty) chk("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_outs"}, {16'd0, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_carry,
            bus.req0_ready, bus.req1_ready, alu_op}, 32'd0);
        chk({tag, "_data"}, {20'd0, bus.rsp_result, alu_a, alu_b}, 32'd0);
    endtask

    initial begin
        set_req(0, 1'b0, 4'd0, 4'd0, 3'd0);
        set_req(1, 1'b0, 4'd0, 4'd0, 3'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single ADD, then ADD overflow on req1
        ord_q.push_back(0);
        drive(0, 4'd5, 4'd5, OP_ADD, 4'd10, 1'b0);
        drain();
        ord_q.push_back(1);
        drive(1, 4'd13, 4'd7, OP_ADD, 4'd4, 1'b1);
        drain();

        // simultaneous after reset: pointer 0 favours req0
        rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1; @(posedge clk); #1;
        ord_q.push_back(0); ord_q.push_back(1);
        fork
            drive(0, 4'd15, 4'd3, OP_SUB, 4'd12, 1'b0);
            drive(1, 4'b1101, 4'b1011, OP_AND, 4'b1001, 1'b0);
        join
        drain();

        // fairness: both hold valid, grants alternate, one response per 3 cycles
        rsp_cyc.delete();
        ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(0); ord_q.push_back(1);
        fork
            begin
                drive(0, 4'b0101, 4'b0011, OP_OR, 4'b0111, 1'b0);
                drive(0, 4'b0101, 4'b0011, OP_OR, 4'b0111, 1'b0);
            end
            begin
                drive(1, 4'b1101, 4'b0111, OP_XOR, 4'b1010, 1'b0);
                drive(1, 4'b1101, 4'b0111, OP_XOR, 4'b1010, 1'b0);
            end
        join
        drain();
        chk("fair_rsp_count", rsp_cyc.size(), 4);
        for (int i = 1; i < rsp_cyc.size(); i++)
            chk("fair_rsp_spacing", rsp_cyc[i] - rsp_cyc[i-1], 3);

        // stall: req1 waits while req0 is in flight
        ord_q.push_back(0); ord_q.push_back(1);
        fork
            drive(0, 4'd2, 4'd3, OP_ADD, 4'd5, 1'b0);
            begin
                @(posedge clk); #1;
                drive(1, 4'b0101, 4'b0000, OP_NOT, 4'b1010, 1'b0);
            end
            begin
                @(posedge clk);
                @(negedge clk); chk("stall_ready1_wait", {31'd0, bus.req1_ready}, 32'd0);
                @(negedge clk); chk("stall_ready1_resp", {31'd0, bus.req1_ready}, 32'd0);
            end
        join
        drain();

        // reset mid-WAIT, with pointer first moved to 1 by a req0-only op
        ord_q.push_back(0);
        drive(0, 4'd1, 4'd1, OP_ADD, 4'd2, 1'b0);
        drain();
        drive(0, 4'b1110, 4'd2, OP_SHL, 4'b1000, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("post_reset");
        @(posedge clk); #1;
        ord_q.push_back(0); ord_q.push_back(1);
        fork
            drive(0, 4'd1, 4'd2, OP_OR, 4'd3, 1'b0);
            drive(1, 4'd4, 4'd8, OP_OR, 4'd12, 1'b0);
        join
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
